// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the programmable clock divider.
// Optional feature macro: DIV_CTRL_TICK_CNT_EN (adds the tick_count output).
package div_ctrl_pkg;

    // Default width of the terminal-count register
    localparam int DIV_W_DEFAULT = 32;

    // Control FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    // Terminal count that gives a toggle rate of f_out from a clock of f_in
    function automatic int unsigned reset_term(input int unsigned f_in,
                                               input int unsigned f_out);
        return (f_in / f_out) - 32'd1;
    endfunction

endpackage

// File: rtl/div_ctrl_core.sv
// Divider datapath: counter, active terminal count, slow output and tick pulse.
// Counting is enabled by cnt_en; dropping cnt_en clears counter and slow.
// load_term replaces the terminal count on the next edge.
module div_ctrl_core
    import div_ctrl_pkg::*;
#(
    parameter int               DIV_W    = DIV_W_DEFAULT,
    parameter logic [DIV_W-1:0] TERM_RST = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cnt_en,
    input  logic             load_term,
    input  logic [DIV_W-1:0] term_in,
    output logic             at_term,
    output logic             slow,
    output logic             tick
);

    logic [DIV_W-1:0] counter_reg;
    logic [DIV_W-1:0] term_reg;
    logic             slow_reg;
    logic             tick_reg;

    assign at_term = (counter_reg == term_reg);
    assign slow    = slow_reg;
    assign tick    = tick_reg;

    // Count up to term, wrap to 0 and toggle slow; tick marks the toggle cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter_reg <= '0;
            slow_reg    <= 1'b0;
            tick_reg    <= 1'b0;
        end else begin
            tick_reg <= 1'b0;
            if (!cnt_en) begin
                counter_reg <= '0;
                slow_reg    <= 1'b0;
            end else if (at_term) begin
                counter_reg <= '0;
                slow_reg    <= ~slow_reg;
                tick_reg    <= 1'b1;
            end else begin
                counter_reg <= counter_reg + DIV_W'(1);
            end
        end
    end

    // Terminal count only changes when the controller asks; the counter is
    // always 0 at that moment, so it can never exceed the new term
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            term_reg <= TERM_RST;
        end else if (load_term) begin
            term_reg <= term_in;
        end
    end

endmodule

// File: rtl/div_ctrl.sv
// Programmable square-wave divider: FSM, config handshake, shadow register
// and error pulse around the div_ctrl_core datapath.
// Optional feature macro: DIV_CTRL_TICK_CNT_EN adds a 16-bit wrapping
// tick_count output cleared only by reset.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int unsigned fin   = 100000000,
    parameter int unsigned fout  = 50,
    parameter int          DIV_W = DIV_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             slow,
    output logic             tick,
    output logic             busy
`ifdef DIV_CTRL_TICK_CNT_EN
    ,
    output logic [15:0]      tick_count
`endif
);

    localparam logic [DIV_W-1:0] TERM_RST = DIV_W'(reset_term(fin, fout));

    state_t           state_reg;
    state_t           state_next;
    logic [DIV_W-1:0] shadow_reg;
    logic             cfg_err_reg;
    logic             cfg_accept;
    logic             cfg_legal;
    logic             cnt_en;
    logic             load_term;
    logic [DIV_W-1:0] term_in;
    logic             at_term;

    assign cfg_accept = cfg_valid && cfg_ready;
    assign cfg_legal  = (cfg_div != '0);
    assign cfg_err    = cfg_err_reg;

    div_ctrl_core #(
        .DIV_W    (DIV_W),
        .TERM_RST (TERM_RST)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .cnt_en    (cnt_en),
        .load_term (load_term),
        .term_in   (term_in),
        .at_term   (at_term),
        .slow      (slow),
        .tick      (tick)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; dropping run always wins and returns to IDLE
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (run) state_next = RUN;
            RUN: begin
                if (!run)                          state_next = IDLE;
                else if (cfg_accept && cfg_legal)  state_next = PEND;
            end
            PEND: begin
                if (!run)         state_next = IDLE;
                else if (at_term) state_next = RUN;
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs and datapath control; a new term is only loaded while the
    // counter is (or is being forced to) 0, so half-periods never glitch
    always_comb begin
        cfg_ready = (state_reg != PEND);
        busy      = (state_reg == PEND);
        cnt_en    = run && (state_reg != IDLE);
        load_term = 1'b0;
        term_in   = cfg_div;
        case (state_reg)
            IDLE: load_term = cfg_accept && cfg_legal;
            RUN:  load_term = !run && cfg_accept && cfg_legal;
            PEND: begin
                load_term = !run || at_term;
                term_in   = shadow_reg;
            end
            default: load_term = 1'b0;
        endcase
    end

    // Capture a legal config offered while running; applied at the next boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_reg <= '0;
        end else if ((state_reg == RUN) && run && cfg_accept && cfg_legal) begin
            shadow_reg <= cfg_div;
        end
    end

    // One-cycle error pulse after accepting a zero terminal count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err_reg <= 1'b0;
        end else begin
            cfg_err_reg <= cfg_accept && !cfg_legal;
        end
    end

`ifdef DIV_CTRL_TICK_CNT_EN
    logic [15:0] tick_count_reg;

    assign tick_count = tick_count_reg;

    // Free-running count of ticks, wraps naturally at 16 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_count_reg <= '0;
        end else if (tick) begin
            tick_count_reg <= tick_count_reg + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl with fin=100, fout=10 (reset term 9).
// The reference works in half-period lengths: each boundary is spaced
// term+1 cycles apart, and a config changes the spacing from the boundary
// after the one in progress (or one later if offered on the boundary cycle).
module tb_div_ctrl;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          run = 1'b0;
    logic          cfg_valid = 1'b0;
    logic [DW-1:0] cfg_div = '0;
    logic          cfg_ready, cfg_err, slow, tick, busy;
`ifdef DIV_CTRL_TICK_CNT_EN
    logic [15:0]   tick_count;
`endif

    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   n_ticks = 0;
    int   cur_term = 9;
    logic slow_prev = 1'b0;
    int   tick_q[$];

    always #5 clk = ~clk;

    div_ctrl #(.fin(100), .fout(10), .DIV_W(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .cfg_valid  (cfg_valid),
        .cfg_div    (cfg_div),
        .cfg_ready  (cfg_ready),
        .cfg_err    (cfg_err),
        .slow       (slow),
        .tick       (tick),
        .busy       (busy)
`ifdef DIV_CTRL_TICK_CNT_EN
        ,
        .tick_count (tick_count)
`endif
    );

    // Advance one clock; record ticks and check tick coincides with a slow toggle
    task automatic step(input bit chk_align = 1'b1);
        @(posedge clk);
        #1;
        cyc++;
        if (chk_align) begin
            n_cmp++;
            if ((slow !== slow_prev) !== tick) begin
                n_fail++;
                $display("FAIL tick_align cyc=%0d: tick=%b slow=%b prev_slow=%b", cyc, tick, slow, slow_prev);
            end
        end
        slow_prev = slow;
        if (tick === 1'b1) begin
            tick_q.push_back(cyc);
            n_ticks++;
        end
    endtask

    // Step until n ticks are recorded, with a cycle budget
    task automatic collect(input int n);
        int guard = 0;
        while (tick_q.size() < n && guard < 1000) begin
            step();
            guard++;
        end
        n_cmp++;
        if (tick_q.size() < n) begin
            n_fail++;
            $display("FAIL collect: got %0d ticks, required %0d", tick_q.size(), n);
        end
    endtask

    // Synchronise to a boundary: on return the counter is 0 and tick_q = {t0}
    task automatic wait_tick();
        tick_q.delete();
        collect(1);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({slow, tick, busy, cfg_err, cfg_ready} !== 5'b00001) begin
            n_fail++;
            $display("FAIL reset_outputs: slow,tick,busy,cfg_err,cfg_ready=%b required 00001",
                     {slow, tick, busy, cfg_err, cfg_ready});
        end
        repeat (3) step();
        rst_n = 1'b1;
        repeat (2) step();
        n_cmp++;
        if ({slow, tick, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL idle_hold: slow,tick,busy=%b required 000", {slow, tick, busy});
        end
        $display("reset: outputs checked");
    endtask

    task automatic test_basic();
        int start;
        run = 1'b1;
        tick_q.delete();
        start = cyc;
        collect(5);
        n_cmp++;
        if (tick_q.size() >= 1 && tick_q[0] - start != 11) begin
            n_fail++;
            $display("FAIL first_tick: %0d cycles, required 11", tick_q[0] - start);
        end
        for (int i = 0; i + 1 < tick_q.size(); i++) begin
            n_cmp++;
            if (tick_q[i+1] - tick_q[i] != 10) begin
                n_fail++;
                $display("FAIL basic_period[%0d]: %0d required 10", i, tick_q[i+1] - tick_q[i]);
            end
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_busy: %b required 0", busy);
        end
        $display("basic: %0d ticks at term 9", tick_q.size());
    endtask

    // Offer cfg_div=d when counter=p and check the resulting half-periods
    task automatic test_cfg(input int p, input int d);
        int exp_q[$];
        int old = cur_term;
        if (p == old) exp_q = '{old + 1, old + 1, d + 1, d + 1};
        else          exp_q = '{old + 1, d + 1, d + 1};
        wait_tick();
        repeat (p) step();
        n_cmp++;
        if (cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL cfg_ready_run: %b required 1", cfg_ready);
        end
        cfg_valid = 1'b1;
        cfg_div   = DW'(d);
        step();
        cfg_valid = 1'b0;
        n_cmp++;
        if ({busy, cfg_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL cfg_pend p=%0d: busy,cfg_ready=%b required 10", p, {busy, cfg_ready});
        end
        collect(exp_q.size() + 1);
        for (int i = 0; i < exp_q.size() && i + 1 < tick_q.size(); i++) begin
            n_cmp++;
            if (tick_q[i+1] - tick_q[i] != exp_q[i]) begin
                n_fail++;
                $display("FAIL cfg_half[%0d] p=%0d old=%0d new=%0d: %0d required %0d",
                         i, p, old, d, tick_q[i+1] - tick_q[i], exp_q[i]);
            end
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL cfg_busy_clear: %b required 0", busy);
        end
        cur_term = d;
        $display("cfg: old=%0d new=%0d offered at counter=%0d", old, d, p);
    endtask

    task automatic test_cfg_err();
        int p = $urandom_range(cur_term, 0);
        wait_tick();
        repeat (p) step();
        cfg_valid = 1'b1;
        cfg_div   = '0;
        step();
        cfg_valid = 1'b0;
        n_cmp++;
        if ({cfg_err, busy, cfg_ready} !== 3'b101) begin
            n_fail++;
            $display("FAIL err_pulse: cfg_err,busy,cfg_ready=%b required 101", {cfg_err, busy, cfg_ready});
        end
        step();
        n_cmp++;
        if ({cfg_err, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL err_clear: cfg_err,busy=%b required 00", {cfg_err, busy});
        end
        collect(3);
        for (int i = 0; i + 1 < tick_q.size(); i++) begin
            n_cmp++;
            if (tick_q[i+1] - tick_q[i] != cur_term + 1) begin
                n_fail++;
                $display("FAIL err_period[%0d]: %0d required %0d", i, tick_q[i+1] - tick_q[i], cur_term + 1);
            end
        end
        $display("cfg_err: zero offered at counter=%0d, term stays %0d", p, cur_term);
    endtask

    task automatic test_drop_run_pend();
        int start;
        wait_tick();
        cfg_valid = 1'b1;
        cfg_div   = DW'(2);
        step();
        cfg_valid = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_pend: busy=%b required 1", busy);
        end
        run = 1'b0;
        step(1'b0);
        slow_prev = slow;
        n_cmp++;
        if ({slow, tick, busy, cfg_ready} !== 4'b0001) begin
            n_fail++;
            $display("FAIL drop_idle: slow,tick,busy,cfg_ready=%b required 0001", {slow, tick, busy, cfg_ready});
        end
        repeat (3) step();
        run = 1'b1;
        tick_q.delete();
        start = cyc;
        collect(3);
        n_cmp++;
        if (tick_q.size() >= 1 && tick_q[0] - start != 4) begin
            n_fail++;
            $display("FAIL drop_restart: first tick after %0d cycles, required 4", tick_q[0] - start);
        end
        for (int i = 0; i + 1 < tick_q.size(); i++) begin
            n_cmp++;
            if (tick_q[i+1] - tick_q[i] != 3) begin
                n_fail++;
                $display("FAIL drop_period[%0d]: %0d required 3", i, tick_q[i+1] - tick_q[i]);
            end
        end
        cur_term = 2;
        $display("drop_run: shadow 2 committed in IDLE");
    endtask

    task automatic test_async_reset();
        int start;
        int d = $urandom_range(6, 1);
        wait_tick();
        cfg_valid = 1'b1;
        cfg_div   = DW'(d);
        step();
        cfg_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({slow, tick, busy, cfg_err, cfg_ready} !== 5'b00001) begin
            n_fail++;
            $display("FAIL async_reset: slow,tick,busy,cfg_err,cfg_ready=%b required 00001",
                     {slow, tick, busy, cfg_err, cfg_ready});
        end
        slow_prev = 1'b0;
        n_ticks   = 0;
        repeat (2) step();
        rst_n = 1'b1;
        tick_q.delete();
        start = cyc;
        collect(3);
        n_cmp++;
        if (tick_q.size() >= 1 && tick_q[0] - start != 11) begin
            n_fail++;
            $display("FAIL reset_restart: first tick after %0d, required 11", tick_q[0] - start);
        end
        for (int i = 0; i + 1 < tick_q.size(); i++) begin
            n_cmp++;
            if (tick_q[i+1] - tick_q[i] != 10) begin
                n_fail++;
                $display("FAIL reset_period[%0d]: %0d required 10 (pending %0d lost)",
                         i, tick_q[i+1] - tick_q[i], d);
            end
        end
        cur_term = 9;
        $display("async_reset: pending cfg %0d discarded", d);
`ifdef DIV_CTRL_TICK_CNT_EN
        n_cmp++;
        if (tick_count !== 16'(n_ticks)) begin
            n_fail++;
            $display("FAIL tick_count: %0d required %0d", tick_count, n_ticks);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_cfg(3, 4);
        test_cfg(2, 9);
        test_cfg(9, 4);
        for (int k = 0; k < 4; k++) begin
            test_cfg($urandom_range(cur_term, 0), $urandom_range(7, 1));
        end
        test_cfg_err();
        test_cfg(0, 5);
        test_drop_run_pend();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
